// File: rtl/rf_pkg.sv
// Shared constants and types for the general-purpose register file.
// The decode and writeback stages import this package so their
// register-address ports are sized the same way as the register file's.
//   RF_NUM_REGS   : default number of architectural registers
//   RF_DATA_WIDTH : default register width in bits
//   RF_ADDR_WIDTH : address width implied by RF_NUM_REGS
//   rf_addr_t     : register address type at the default geometry
package rf_pkg;

  localparam int RF_NUM_REGS   = 32;
  localparam int RF_DATA_WIDTH = 32;
  localparam int RF_ADDR_WIDTH = $clog2(RF_NUM_REGS);

  typedef logic [RF_ADDR_WIDTH-1:0] rf_addr_t;

endpackage

// File: rtl/rf_read_port.sv
// One registered read port of the register file.
// Ports:
//   clk, reset : clock and asynchronous active-high reset (clears rdata)
//   read_en    : when 1, rdata is loaded on the rising edge; when 0 it holds
//   raddr      : register to read
//   write_en   : write strobe of the shared write port (for bypass)
//   waddr      : write address of the shared write port (for bypass)
//   wdata      : write data of the shared write port (for bypass)
//   rf         : current contents of the storage array
//   rdata      : registered read data
// There is no handshake: a read is accepted on every edge with read_en=1
// and its data is valid from that edge until the next enabled read.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int NUM_REGS   = RF_NUM_REGS,
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  read_en,
  input  logic [ADDR_WIDTH-1:0] raddr,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rf [NUM_REGS],
  output logic [DATA_WIDTH-1:0] rdata
);

  // One extra bit so NUM_REGS itself is representable when it is a power of two.
  localparam logic [ADDR_WIDTH:0] REG_LIMIT = (ADDR_WIDTH + 1)'(NUM_REGS);

  logic                  raddr_ok;
  logic                  bypass_hit;
  logic [DATA_WIDTH-1:0] next_data;

  assign raddr_ok = ({1'b0, raddr} < REG_LIMIT);
  // raddr_ok already implies waddr is in range when the two addresses match.
  assign bypass_hit = write_en && (waddr == raddr);

  always_comb begin
    next_data = '0;
    if (!raddr_ok) begin
      next_data = '0;
    end else if (bypass_hit) begin
      // Write landing on this edge wins over the stale array contents.
      next_data = wdata;
    end else begin
      next_data = rf[raddr];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata <= '0;
    end else if (read_en) begin
      rdata <= next_data;
    end
  end

endmodule

// File: rtl/register_file_2r1w.sv
// Two-read, one-write general-purpose register file for operand fetch and
// writeback. All NUM_REGS registers are general purpose (r0 is writable).
// Ports:
//   clk      : clock, all state updates on the rising edge
//   reset    : asynchronous active-high reset, clears RF and both rdata
//   read_en  : bit k enables read port k
//   write_en : write strobe
//   raddr_0  : read port 0 address
//   raddr_1  : read port 1 address
//   waddr    : write address (out-of-range writes are dropped)
//   wdata    : write data
//   rdata_0  : read port 0 data, registered, 1-cycle latency
//   rdata_1  : read port 1 data, registered, 1-cycle latency
// The storage array is named RF so it can be inspected hierarchically.
module register_file_2r1w
  import rf_pkg::*;
#(
  parameter int NUM_REGS   = RF_NUM_REGS,
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            read_en,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] raddr_0,
  input  logic [ADDR_WIDTH-1:0] raddr_1,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata_0,
  output logic [DATA_WIDTH-1:0] rdata_1
);

  localparam logic [ADDR_WIDTH:0] REG_LIMIT = (ADDR_WIDTH + 1)'(NUM_REGS);

  logic [DATA_WIDTH-1:0] RF [NUM_REGS];
  logic                  waddr_ok;

  assign waddr_ok = ({1'b0, waddr} < REG_LIMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        RF[i] <= '0;
      end
    end else if (write_en && waddr_ok) begin
      RF[waddr] <= wdata;
    end
  end

  rf_read_port #(
    .NUM_REGS   (NUM_REGS),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_read_port_0 (
    .clk      (clk),
    .reset    (reset),
    .read_en  (read_en[0]),
    .raddr    (raddr_0),
    .write_en (write_en),
    .waddr    (waddr),
    .wdata    (wdata),
    .rf       (RF),
    .rdata    (rdata_0)
  );

  rf_read_port #(
    .NUM_REGS   (NUM_REGS),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_read_port_1 (
    .clk      (clk),
    .reset    (reset),
    .read_en  (read_en[1]),
    .raddr    (raddr_1),
    .write_en (write_en),
    .waddr    (waddr),
    .wdata    (wdata),
    .rf       (RF),
    .rdata    (rdata_1)
  );

endmodule

// File: tb/tb_register_file_2r1w.sv
module tb_register_file_2r1w;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- main DUT (default geometry) ----------------
  logic [1:0]  read_en  = '0;
  logic        write_en = 1'b0;
  logic [4:0]  raddr_0  = '0;
  logic [4:0]  raddr_1  = '0;
  logic [4:0]  waddr    = '0;
  logic [31:0] wdata    = '0;
  logic [31:0] rdata_0;
  logic [31:0] rdata_1;

  register_file_2r1w dut (
    .clk      (clk),
    .reset    (reset),
    .read_en  (read_en),
    .write_en (write_en),
    .raddr_0  (raddr_0),
    .raddr_1  (raddr_1),
    .waddr    (waddr),
    .wdata    (wdata),
    .rdata_0  (rdata_0),
    .rdata_1  (rdata_1)
  );

  // ---------------- small DUT: 6 regs, so out-of-range addresses exist ----------------
  logic [1:0]  s_read_en  = '0;
  logic        s_write_en = 1'b0;
  logic [2:0]  s_raddr_0  = '0;
  logic [2:0]  s_raddr_1  = '0;
  logic [2:0]  s_waddr    = '0;
  logic [7:0]  s_wdata    = '0;
  logic [7:0]  s_rdata_0;
  logic [7:0]  s_rdata_1;

  register_file_2r1w #(.NUM_REGS(6), .DATA_WIDTH(8)) dut_s (
    .clk      (clk),
    .reset    (reset),
    .read_en  (s_read_en),
    .write_en (s_write_en),
    .raddr_0  (s_raddr_0),
    .raddr_1  (s_raddr_1),
    .waddr    (s_waddr),
    .wdata    (s_wdata),
    .rdata_0  (s_rdata_0),
    .rdata_1  (s_rdata_1)
  );

  // ---------------- scoreboard counters ----------------
  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of the main DUT ----------------
  // Reads see the write of the same edge; reads with read_en low keep the old value.
  logic [31:0] m_rf [32];
  logic [31:0] m_r0 = '0;
  logic [31:0] m_r1 = '0;
  logic [31:0] exp_q[$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      foreach (m_rf[i]) m_rf[i] = '0;
      m_r0 = '0;
      m_r1 = '0;
    end else begin
      logic [31:0] v0, v1;
      v0 = (write_en && waddr == raddr_0) ? wdata : m_rf[raddr_0];
      v1 = (write_en && waddr == raddr_1) ? wdata : m_rf[raddr_1];
      if (read_en[0]) m_r0 = v0;
      if (read_en[1]) m_r1 = v1;
      if (write_en) m_rf[waddr] = wdata;
    end
  end

  // Single compare process: every falling edge outside reset.
  always @(negedge clk) begin
    if (cmp_en && !reset) begin
      exp_q.push_back(m_r0);
      exp_q.push_back(m_r1);
      check("model_rdata_0", rdata_0, exp_q.pop_front());
      check("model_rdata_1", rdata_1, exp_q.pop_front());
    end
  end

  // ---------------- driver ----------------
  // Called at a falling edge; applies inputs and returns at the next falling edge.
  task automatic drive(input logic [1:0] re, input logic we, input logic [4:0] a0,
                       input logic [4:0] a1, input logic [4:0] wa, input logic [31:0] wd);
    read_en  = re;
    write_en = we;
    raddr_0  = a0;
    raddr_1  = a1;
    waddr    = wa;
    wdata    = wd;
    @(negedge clk);
  endtask

  task automatic drive_s(input logic [1:0] re, input logic we, input logic [2:0] a0,
                         input logic [2:0] a1, input logic [2:0] wa, input logic [7:0] wd);
    s_read_en  = re;
    s_write_en = we;
    s_raddr_0  = a0;
    s_raddr_1  = a1;
    s_waddr    = wa;
    s_wdata    = wd;
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset default
    repeat (10) @(negedge clk);
    for (int i = 0; i < 32; i++) check($sformatf("reset_rf_%0d", i), dut.RF[i], 32'h0);
    check("reset_rdata_0", rdata_0, 32'h0);
    check("reset_rdata_1", rdata_1, 32'h0);
    reset  = 1'b0;
    cmp_en = 1'b1;

    // Write / read
    drive(2'b00, 1'b1, 5'd0, 5'd0, 5'd5,  32'hDEADBEEF);
    drive(2'b00, 1'b1, 5'd0, 5'd0, 5'd31, 32'h12345678);
    drive(2'b11, 1'b0, 5'd5, 5'd31, 5'd0, 32'h0);
    check("wr_rd_port0", rdata_0, 32'hDEADBEEF);
    check("wr_rd_port1", rdata_1, 32'h12345678);

    // Bypass: r7 holds 1, then write and read r7 on the same edge
    drive(2'b00, 1'b1, 5'd0, 5'd0, 5'd7, 32'h00000001);
    drive(2'b01, 1'b1, 5'd7, 5'd0, 5'd7, 32'hCAFEF00D);
    check("bypass_port0", rdata_0, 32'hCAFEF00D);
    check("bypass_port1_held", rdata_1, 32'h12345678);

    // Hold: read r5, then drop enable, move address, overwrite r5
    drive(2'b01, 1'b0, 5'd5, 5'd0, 5'd0, 32'h0);
    check("hold_pre", rdata_0, 32'hDEADBEEF);
    drive(2'b00, 1'b1, 5'd31, 5'd0, 5'd5, 32'h55555555);
    check("hold_port0", rdata_0, 32'hDEADBEEF);
    check("hold_rf5_written", dut.RF[5], 32'h55555555);
    drive(2'b00, 1'b1, 5'd0, 5'd0, 5'd5, 32'hDEADBEEF);

    // Same-address dual read
    drive(2'b11, 1'b0, 5'd5, 5'd5, 5'd0, 32'h0);
    check("same_addr_port0", rdata_0, 32'hDEADBEEF);
    check("same_addr_port1", rdata_1, 32'hDEADBEEF);

    // Bypass on port 1 only, port 0 reads a different register
    drive(2'b11, 1'b1, 5'd31, 5'd0, 5'd0, 32'h0BADF00D);
    check("bypass_port1", rdata_1, 32'h0BADF00D);
    check("no_bypass_port0", rdata_0, 32'h12345678);

    // Directed sweep: fill every register, mixed enables and read addresses
    for (int i = 0; i < 32; i++) begin
      drive(2'(i % 4), 1'b1, 5'((i * 7) % 32), 5'(31 - i), 5'(i),
            (32'h01010101 * 32'(i)) ^ 32'hA5A50F0F);
    end
    drive(2'b11, 1'b0, 5'd9, 5'd0, 5'd0, 32'h0);
    check("sweep_r9", rdata_0, 32'hACAC0606);
    check("sweep_r0", rdata_1, 32'hA5A50F0F);

    // Reset between edges with a write pending
    read_en  = 2'b11;
    write_en = 1'b1;
    waddr    = 5'd9;
    wdata    = 32'hFFFFFFFF;
    raddr_0  = 5'd9;
    raddr_1  = 5'd9;
    #2 reset = 1'b1;
    #1;
    check("async_reset_rdata_0", rdata_0, 32'h0);
    check("async_reset_rdata_1", rdata_1, 32'h0);
    check("async_reset_rf9", dut.RF[9], 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    drive(2'b11, 1'b0, 5'd9, 5'd5, 5'd0, 32'h0);
    check("post_reset_r9", rdata_0, 32'h0);
    check("post_reset_r5", rdata_1, 32'h0);
    check("post_reset_rf9", dut.RF[9], 32'h0);

    // Out-of-range handling on the 6-register instance
    drive_s(2'b00, 1'b1, 3'd0, 3'd0, 3'd3, 8'h3C);
    drive_s(2'b00, 1'b1, 3'd0, 3'd0, 3'd7, 8'hEE);
    drive_s(2'b11, 1'b0, 3'd3, 3'd6, 3'd0, 8'h00);
    check("s_read_r3", 32'(s_rdata_0), 32'h3C);
    check("s_read_oor6", 32'(s_rdata_1), 32'h0);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("s_rf_%0d", i), 32'(dut_s.RF[i]), (i == 3) ? 32'h3C : 32'h0);
    end
    drive_s(2'b11, 1'b1, 3'd6, 3'd3, 3'd6, 8'h77);
    check("s_bypass_oor", 32'(s_rdata_0), 32'h0);
    check("s_read_r3_again", 32'(s_rdata_1), 32'h3C);
    drive_s(2'b10, 1'b1, 3'd0, 3'd0, 3'd0, 8'h5A);
    check("s_bypass_r0", 32'(s_rdata_1), 32'h5A);
    check("s_hold_port0", 32'(s_rdata_0), 32'h0);
    drive_s(2'b00, 1'b0, 3'd0, 3'd0, 3'd0, 8'h00);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
